// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit for the phase-2 CPU. Fetches each
//               instruction (PC -> MAR -> MDR -> IR), decodes IR and steps
//               through the execute T-states of R-format ALU instructions,
//               driving every datapath strobe as a Moore decode of state+IR.
// Ports       : Clock        - system clock, rising edge
//               Clear        - asynchronous active-low reset
//               Run          - execute enable, sampled in IDLE / last T-state
//               IR[31:0]     - instruction register (op, Ra, Rb, Rc fields)
//               *out         - bus drive strobes (PC, MDR, Zhigh, Zlow, HI, LO)
//               *in/IncPC/Read - register load and memory strobes
//               Rout/Rin     - one-hot GPR drive / load
//               ALUop[12:0]  - one-hot ALU operation select
//               Halted       - high while in HALT
//               instr_count  - retired-instruction counter (wraps)
//               state_dbg    - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             MDRout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIout,
    output logic             LOout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Zin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [15:0]      Rout,
    output logic [15:0]      Rin,
    output logic [12:0]      ALUop,
    output logic             Halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    // State encoding
    localparam logic [3:0] c_IDLE = 4'd0;
    localparam logic [3:0] c_T0   = 4'd1;
    localparam logic [3:0] c_T1   = 4'd2;
    localparam logic [3:0] c_T2   = 4'd3;
    localparam logic [3:0] c_T3   = 4'd4;
    localparam logic [3:0] c_T4   = 4'd5;
    localparam logic [3:0] c_T5   = 4'd6;
    localparam logic [3:0] c_T6   = 4'd7;
    localparam logic [3:0] c_HALT = 4'd8;

    // Where an illegal opcode sends the sequencer after its decode cycle
    localparam logic [3:0] c_ILLEGAL_NEXT = HALT_ON_ILLEGAL ? c_HALT : c_T0;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_instr_count;

    // IR fields
    logic [4:0] w_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = ^IR[14:0];

    // Instruction class decode
    logic w_is_bin;
    logic w_is_md;
    logic w_is_un;
    logic w_illegal;
    logic w_last;

    assign w_is_bin  = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_is_md   = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_is_un   = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_illegal = !(w_is_bin || w_is_md || w_is_un);

    // Final T-state of the instruction currently in IR; the only place
    // (besides IDLE) where Run is sampled and the counter advances.
    assign w_last = ((r_state == c_T4) && w_is_un)  ||
                    ((r_state == c_T5) && w_is_bin) ||
                    ((r_state == c_T6) && w_is_md);

    function automatic logic [15:0] f_reg_oh(input logic [3:0] idx);
        f_reg_oh = 16'h0001 << idx;
    endfunction

    // ALUop bit order, MSB first: ADD SUB SHR SHRA SHL ROR ROL AND OR MUL DIV NEG NOT
    function automatic logic [12:0] f_alu_oh(input logic [4:0] op);
        case (op)
            5'd3:    f_alu_oh = 13'b1_0000_0000_0000; // add
            5'd4:    f_alu_oh = 13'b0_1000_0000_0000; // sub
            5'd9:    f_alu_oh = 13'b0_0100_0000_0000; // shr
            5'd10:   f_alu_oh = 13'b0_0010_0000_0000; // shra
            5'd11:   f_alu_oh = 13'b0_0001_0000_0000; // shl
            5'd7:    f_alu_oh = 13'b0_0000_1000_0000; // ror
            5'd8:    f_alu_oh = 13'b0_0000_0100_0000; // rol
            5'd5:    f_alu_oh = 13'b0_0000_0010_0000; // and
            5'd6:    f_alu_oh = 13'b0_0000_0001_0000; // or
            5'd15:   f_alu_oh = 13'b0_0000_0000_1000; // mul
            5'd16:   f_alu_oh = 13'b0_0000_0000_0100; // div
            5'd17:   f_alu_oh = 13'b0_0000_0000_0010; // neg
            5'd18:   f_alu_oh = 13'b0_0000_0000_0001; // not
            default: f_alu_oh = 13'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: w_next_state = Run ? c_T0 : c_IDLE;
            c_T0:   w_next_state = c_T1;
            c_T1:   w_next_state = c_T2;
            c_T2:   w_next_state = c_T3;
            c_T3:   w_next_state = w_illegal ? c_ILLEGAL_NEXT : c_T4;
            c_T4:   w_next_state = w_last ? (Run ? c_T0 : c_IDLE) : c_T5;
            c_T5:   w_next_state = w_last ? (Run ? c_T0 : c_IDLE) : c_T6;
            c_T6:   w_next_state = Run ? c_T0 : c_IDLE;
            c_HALT: w_next_state = c_HALT;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state       <= c_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_last) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode: strobes depend only on state and IR, so they
    // are stable for a full cycle before the datapath samples them.
    // ------------------------------------------------------------------
    always_comb begin
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Zin      = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        ALUop    = 13'h0000;
        case (r_state)
            c_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            c_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            c_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            c_T3: begin
                if (w_is_bin) begin
                    Rout = f_reg_oh(w_rb);
                    Yin  = 1'b1;
                end else if (w_is_md) begin
                    Rout = f_reg_oh(w_ra);
                    Yin  = 1'b1;
                end else if (w_is_un) begin
                    Rout  = f_reg_oh(w_rb);
                    ALUop = f_alu_oh(w_op);
                    Zin   = 1'b1;
                end
            end
            c_T4: begin
                if (w_is_bin) begin
                    Rout  = f_reg_oh(w_rc);
                    ALUop = f_alu_oh(w_op);
                    Zin   = 1'b1;
                end else if (w_is_md) begin
                    Rout  = f_reg_oh(w_rb);
                    ALUop = f_alu_oh(w_op);
                    Zin   = 1'b1;
                end else if (w_is_un) begin
                    Zlowout = 1'b1;
                    Rin     = f_reg_oh(w_ra);
                end
            end
            c_T5: begin
                if (w_is_bin) begin
                    Zlowout = 1'b1;
                    Rin     = f_reg_oh(w_ra);
                end else if (w_is_md) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            c_T6: begin
                if (w_is_md) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Halted      = (r_state == c_HALT);
    assign instr_count = r_instr_count;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer. Runs
//               and/mul/neg instructions, Run drop, mid-instruction Clear
//               and an illegal opcode into HALT against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic        Run;
    logic [31:0] IR;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic        PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [12:0] ALUop;
    logic        Halted;
    logic [15:0] instr_count;
    logic [3:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Packed view of the 1-bit strobes, MSB first
    logic [15:0] w_strb;
    assign w_strb = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
                     PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read};

    localparam logic [15:0] c_PCOUT    = 16'h8000;
    localparam logic [15:0] c_MDROUT   = 16'h4000;
    localparam logic [15:0] c_ZHIGHOUT = 16'h2000;
    localparam logic [15:0] c_ZLOWOUT  = 16'h1000;
    localparam logic [15:0] c_PCIN     = 16'h0200;
    localparam logic [15:0] c_MARIN    = 16'h0100;
    localparam logic [15:0] c_MDRIN    = 16'h0080;
    localparam logic [15:0] c_IRIN     = 16'h0040;
    localparam logic [15:0] c_ZIN      = 16'h0020;
    localparam logic [15:0] c_YIN      = 16'h0010;
    localparam logic [15:0] c_HIIN     = 16'h0008;
    localparam logic [15:0] c_LOIN     = 16'h0004;
    localparam logic [15:0] c_INCPC    = 16'h0002;
    localparam logic [15:0] c_READ     = 16'h0001;

    localparam logic [15:0] c_F0 = c_PCOUT | c_MARIN | c_INCPC | c_ZIN;
    localparam logic [15:0] c_F1 = c_ZLOWOUT | c_PCIN | c_READ | c_MDRIN;
    localparam logic [15:0] c_F2 = c_MDROUT | c_IRIN;

    localparam logic [12:0] c_A_AND = 13'h0020;
    localparam logic [12:0] c_A_MUL = 13'h0008;
    localparam logic [12:0] c_A_NEG = 13'h0002;

    localparam logic [31:0] c_IR_AND = 32'h2891_8000; // and R1,R2,R3
    localparam logic [31:0] c_IR_MUL = 32'h7988_0000; // mul R3,R1
    localparam logic [31:0] c_IR_NEG = 32'h8A10_0000; // neg R4,R2
    localparam logic [31:0] c_IR_ILL = 32'hF800_0000; // op 31

    control_sequencer #(
        .CNT_W           (16),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .Run         (Run),
        .IR          (IR),
        .PCout       (PCout),
        .MDRout      (MDRout),
        .Zhighout    (Zhighout),
        .Zlowout     (Zlowout),
        .HIout       (HIout),
        .LOout       (LOout),
        .PCin        (PCin),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .IRin        (IRin),
        .Zin         (Zin),
        .Yin         (Yin),
        .HIin        (HIin),
        .LOin        (LOin),
        .IncPC       (IncPC),
        .Read        (Read),
        .Rout        (Rout),
        .Rin         (Rin),
        .ALUop       (ALUop),
        .Halted      (Halted),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [15:0] sb,
                              input logic [15:0] ro, input logic [15:0] ri, input logic [12:0] al);
        chk({tag, ".state"},  {28'h0, state_dbg}, {28'h0, st});
        chk({tag, ".strobe"}, {16'h0, w_strb},    {16'h0, sb});
        chk({tag, ".Rout"},   {16'h0, Rout},      {16'h0, ro});
        chk({tag, ".Rin"},    {16'h0, Rin},       {16'h0, ri});
        chk({tag, ".ALUop"},  {19'h0, ALUop},     {19'h0, al});
        chk({tag, ".Halted"}, {31'h0, Halted},    {31'h0, (st == 4'd8)});
    endtask

    // Starts in T0, checks the three fetch cycles, ends in T3
    task automatic fetch(input string tag);
        expect_cyc({tag, ".T0"}, 4'd1, c_F0, 16'h0, 16'h0, 13'h0);
        tick();
        expect_cyc({tag, ".T1"}, 4'd2, c_F1, 16'h0, 16'h0, 13'h0);
        tick();
        expect_cyc({tag, ".T2"}, 4'd3, c_F2, 16'h0, 16'h0, 13'h0);
        tick();
    endtask

    initial begin
        Clear = 1'b1;
        Run   = 1'b0;
        IR    = 32'h0;
        #2 Clear = 1'b0;
        #1;
        expect_cyc("reset", 4'd0, 16'h0, 16'h0, 16'h0, 13'h0);
        chk("reset.cnt", {16'h0, instr_count}, 32'd0);

        @(negedge Clock);
        Clear = 1'b1;
        Run   = 1'b1;
        IR    = c_IR_AND;
        tick();

        // and R1,R2,R3
        fetch("and");
        expect_cyc("and.T3", 4'd4, c_YIN, 16'h0004, 16'h0, 13'h0);
        tick();
        expect_cyc("and.T4", 4'd5, c_ZIN, 16'h0008, 16'h0, c_A_AND);
        tick();
        expect_cyc("and.T5", 4'd6, c_ZLOWOUT, 16'h0, 16'h0002, 13'h0);
        chk("and.cnt_before", {16'h0, instr_count}, 32'd0);
        tick();
        chk("and.next_state", {28'h0, state_dbg}, 32'd1);
        chk("and.cnt", {16'h0, instr_count}, 32'd1);

        // mul R3,R1 : 7 cycles
        IR = c_IR_MUL;
        fetch("mul");
        expect_cyc("mul.T3", 4'd4, c_YIN, 16'h0008, 16'h0, 13'h0);
        tick();
        expect_cyc("mul.T4", 4'd5, c_ZIN, 16'h0002, 16'h0, c_A_MUL);
        tick();
        expect_cyc("mul.T5", 4'd6, c_ZLOWOUT | c_LOIN, 16'h0, 16'h0, 13'h0);
        tick();
        expect_cyc("mul.T6", 4'd7, c_ZHIGHOUT | c_HIIN, 16'h0, 16'h0, 13'h0);
        chk("mul.cnt_before", {16'h0, instr_count}, 32'd1);
        tick();
        chk("mul.next_state", {28'h0, state_dbg}, 32'd1);
        chk("mul.cnt", {16'h0, instr_count}, 32'd2);

        // neg R4,R2 : 5 cycles
        IR = c_IR_NEG;
        fetch("neg");
        expect_cyc("neg.T3", 4'd4, c_ZIN, 16'h0004, 16'h0, c_A_NEG);
        tick();
        expect_cyc("neg.T4", 4'd5, c_ZLOWOUT, 16'h0, 16'h0010, 13'h0);
        tick();
        chk("neg.next_state", {28'h0, state_dbg}, 32'd1);
        chk("neg.cnt", {16'h0, instr_count}, 32'd3);

        // Run dropped during T4 of a binary op
        IR = c_IR_AND;
        fetch("drop");
        tick();
        Run = 1'b0;
        expect_cyc("drop.T4", 4'd5, c_ZIN, 16'h0008, 16'h0, c_A_AND);
        tick();
        expect_cyc("drop.T5", 4'd6, c_ZLOWOUT, 16'h0, 16'h0002, 13'h0);
        tick();
        expect_cyc("drop.idle", 4'd0, 16'h0, 16'h0, 16'h0, 13'h0);
        chk("drop.cnt", {16'h0, instr_count}, 32'd4);
        tick();
        chk("drop.idle_hold", {28'h0, state_dbg}, 32'd0);
        Run = 1'b1;
        tick();
        chk("drop.restart", {28'h0, state_dbg}, 32'd1);

        // Clear asserted in the middle of T4
        fetch("clr");
        tick();
        chk("clr.inT4", {28'h0, state_dbg}, 32'd5);
        #2 Clear = 1'b0;
        #1;
        expect_cyc("clr.async", 4'd0, 16'h0, 16'h0, 16'h0, 13'h0);
        chk("clr.cnt", {16'h0, instr_count}, 32'd0);
        @(negedge Clock);
        Clear = 1'b1;
        IR    = c_IR_NEG;
        tick();

        // One neg to get a nonzero count, then an illegal opcode
        fetch("neg2");
        tick();
        tick();
        chk("neg2.cnt", {16'h0, instr_count}, 32'd1);
        IR = c_IR_ILL;
        fetch("ill");
        expect_cyc("ill.T3", 4'd4, 16'h0, 16'h0, 16'h0, 13'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            expect_cyc("ill.halt", 4'd8, 16'h0, 16'h0, 16'h0, 13'h0);
            chk("ill.halt_cnt", {16'h0, instr_count}, 32'd1);
            tick();
        end
        #2 Clear = 1'b0;
        #1;
        expect_cyc("ill.clear", 4'd0, 16'h0, 16'h0, 16'h0, 13'h0);
        @(negedge Clock);
        Clear = 1'b1;
        Run   = 1'b0;
        tick();
        expect_cyc("ill.idle", 4'd0, 16'h0, 16'h0, 16'h0, 13'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
